// File: rtl/ifu_pkg.sv
// +----------------------------------------------------------------------+
// | ifu_pkg : shared types for the instruction-fetch sequencer            |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package ifu_pkg;

    localparam int IFU_WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } ifu_state_t;

    typedef struct packed {
        logic [31:0] pc_next;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/ifu_prefetch_queue.sv
// +----------------------------------------------------------------------+
// | ifu_prefetch_queue : synchronous FIFO of fetched words, flush first   |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module ifu_prefetch_queue
    import ifu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    input  logic                     flush,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t    r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [PW:0]     r_count;
    logic            w_push_ok;
    logic            w_pop_ok;

    assign empty     = (r_count == '0);
    assign full      = (r_count == (PW+1)'(DEPTH));
    assign w_pop_ok  = pop && !empty;
    // A full queue can still accept a word when the head leaves in the same cycle.
    assign w_push_ok = push && (!full || w_pop_ok);
    assign head      = r_mem[r_rd_ptr];
    assign count     = r_count;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/ifu_fetch_sequencer.sv
// +----------------------------------------------------------------------+
// | ifu_fetch_sequencer : IF-stage PC owner, fetch handshake, prefetch Q  |
// | optional macro IFU_STATS_EN adds stat_fetched / stat_dropped  rev 1.0 |
// +----------------------------------------------------------------------+
`default_nettype none

module ifu_fetch_sequencer
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'd0,
    parameter int          QUEUE_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_address,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        inst_valid,
    output logic [31:0] instruction,
`ifdef IFU_STATS_EN
    output logic [31:0] stat_fetched,
    output logic [31:0] stat_dropped,
`endif
    output logic [31:0] pc
);

    localparam int             CW        = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CW-1:0]  C_DEPTH   = CW'(QUEUE_DEPTH);
    localparam logic [31:0]    C_ALIGN   = ~32'(IFU_WORD_BYTES - 1);
    localparam logic [31:0]    C_RST_PC  = RESET_PC & C_ALIGN;

    ifu_state_t     r_state;
    logic [31:0]    r_fetch_pc;
    logic [31:0]    r_drop_addr;

    fetch_entry_t   w_head;
    fetch_entry_t   w_push_data;
    logic [CW-1:0]  w_count;
    logic [CW-1:0]  w_count_next;
    logic           w_full;
    logic           w_empty;
    logic           w_issue;
    logic           w_accept;
    logic           w_pop;

    // A redirect suppresses a fresh issue so no old-stream request starts that cycle.
    assign w_issue      = (r_state == IDLE) && !w_full && !branch_taken;
    assign mem_req      = !rst && (w_issue || (r_state == WAIT) || (r_state == DROP));
    assign mem_addr     = (r_state == DROP) ? r_drop_addr : r_fetch_pc;
    assign w_accept     = mem_req && mem_ready && (r_state != DROP) && !branch_taken;
    assign w_pop        = !w_empty && !freeze;
    assign w_count_next = w_count + CW'(w_accept) - CW'(w_pop);
    assign w_push_data  = '{pc_next: r_fetch_pc + 32'(IFU_WORD_BYTES), inst: mem_rdata};

    ifu_prefetch_queue #(
        .DEPTH     (QUEUE_DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (w_accept),
        .push_data (w_push_data),
        .pop       (w_pop),
        .flush     (branch_taken),
        .head      (w_head),
        .count     (w_count),
        .full      (w_full),
        .empty     (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_fetch_pc  <= C_RST_PC;
            r_drop_addr <= C_RST_PC;
        end else if (branch_taken) begin
            r_fetch_pc <= branch_address & C_ALIGN;
            if (mem_req && !mem_ready) begin
                r_state     <= DROP;
                r_drop_addr <= mem_addr;
            end else begin
                r_state <= IDLE;
            end
        end else begin
            case (r_state)
                IDLE, WAIT: begin
                    if (w_accept) begin
                        r_fetch_pc <= r_fetch_pc + 32'(IFU_WORD_BYTES);
                        r_state    <= (w_count_next == C_DEPTH) ? IDLE : WAIT;
                    end else if (w_issue) begin
                        r_state <= WAIT;
                    end
                end
                DROP: begin
                    if (mem_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign inst_valid  = !w_empty;
    assign instruction = w_empty ? 32'd0 : w_head.inst;
    assign pc          = w_empty ? 32'd0 : w_head.pc_next;

`ifdef IFU_STATS_EN
    logic [31:0] r_stat_fetched;
    logic [31:0] r_stat_dropped;
    logic [CW:0] w_drop_inc;
    logic [32:0] w_drop_sum;

    // Dropped words: flushed queue entries plus any word returning for a dead stream.
    assign w_drop_inc = (branch_taken ? {1'b0, w_count} : '0)
                      + (CW+1)'(mem_req && mem_ready && (branch_taken || (r_state == DROP)));
    assign w_drop_sum = {1'b0, r_stat_dropped} + 33'(w_drop_inc);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_fetched <= '0;
            r_stat_dropped <= '0;
        end else begin
            if (w_accept && (r_stat_fetched != '1)) begin
                r_stat_fetched <= r_stat_fetched + 32'd1;
            end
            r_stat_dropped <= w_drop_sum[32] ? '1 : w_drop_sum[31:0];
        end
    end

    assign stat_fetched = r_stat_fetched;
    assign stat_dropped = r_stat_dropped;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ifu_fetch_sequencer.sv
// +----------------------------------------------------------------------+
// | tb_ifu_fetch_sequencer : vectors, corner sequences, random vs model   |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_ifu_fetch_sequencer;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'd0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_address = 32'd0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        inst_valid;
    logic [31:0] instruction;
    logic [31:0] pc;
`ifdef IFU_STATS_EN
    logic [31:0] stat_fetched;
    logic [31:0] stat_dropped;
`endif

    int   total = 0;
    int   bad = 0;
    int   ready_mode = 0;
    int   wait_n = 0;
    int   wcnt = 0;
    logic rnd_rdy = 1'b0;
    logic s_ready = 1'b0;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign mem_rdata = rom(mem_addr);
    assign mem_ready = (ready_mode == 0) ? 1'b1 :
                       (ready_mode == 1) ? rnd_rdy : (wcnt == wait_n);

    always @(posedge clk) wcnt <= (mem_req && !mem_ready) ? wcnt + 1 : 0;
    always #5 clk = ~clk;

    ifu_fetch_sequencer #(
        .RESET_PC       (RST_PC),
        .QUEUE_DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .freeze         (freeze),
        .branch_taken   (branch_taken),
        .branch_address (branch_address),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ready      (mem_ready),
        .mem_rdata      (mem_rdata),
        .inst_valid     (inst_valid),
        .instruction    (instruction),
`ifdef IFU_STATS_EN
        .stat_fetched   (stat_fetched),
        .stat_dropped   (stat_dropped),
`endif
        .pc             (pc)
    );

    // Reference model: queue contents, fetch pointer and the one request in flight.
    typedef struct {
        logic [31:0] pcn;
        logic [31:0] inst;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_fpc = RST_PC;
    int          m_out = 0;          // 0 none, 1 live request, 2 request of a flushed stream
    logic [31:0] m_stale = 32'd0;
    longint      m_fetched = 0;
    longint      m_dropped = 0;
    bit          model_on = 0;

    function automatic logic exp_req();
        return !rst && ((m_out != 0) || ((mq.size() < DEPTH) && !branch_taken));
    endfunction

    function automatic logic [31:0] sat32(input longint v);
        return (v > 64'sh0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        check("m_valid", inst_valid, mq.size() > 0);
        check("m_inst",  instruction, (mq.size() > 0) ? mq[0].inst : 32'd0);
        check("m_pc",    pc, (mq.size() > 0) ? mq[0].pcn : 32'd0);
        check("m_req",   mem_req, exp_req());
        check("m_addr",  mem_addr, (m_out == 2) ? m_stale : m_fpc);
`ifdef IFU_STATS_EN
        check("m_fetched", stat_fetched, sat32(m_fetched));
        check("m_dropped", stat_dropped, sat32(m_dropped));
`endif
    endtask

    task automatic model_update();
        logic req;
        logic acc;
        if (rst) begin
            mq.delete();
            m_fpc = RST_PC;
            m_out = 0;
            m_fetched = 0;
            m_dropped = 0;
            model_on = 1;
            return;
        end
        req = exp_req();
        acc = req && s_ready;
        if (branch_taken) begin
            m_dropped += mq.size() + (acc ? 1 : 0);
            mq.delete();
            if (req && !s_ready) begin
                if (m_out != 2) m_stale = m_fpc;
                m_out = 2;
            end else begin
                m_out = 0;
            end
            m_fpc = {branch_address[31:2], 2'b00};
        end else if (m_out == 2) begin
            if (s_ready) begin
                m_out = 0;
                m_dropped++;
            end
        end else begin
            if ((mq.size() > 0) && !freeze) void'(mq.pop_front());
            if (acc) begin
                mq.push_back('{m_fpc + 32'd4, rom(m_fpc)});
                m_fetched++;
                m_fpc = m_fpc + 32'd4;
            end
            if (req && !s_ready)                   m_out = 1;
            else if (acc && (mq.size() < DEPTH))   m_out = 1;
            else                                   m_out = 0;
        end
    endtask

    // drive(): apply inputs after negedge and run the model check; advance(): clock edge.
    task automatic drive(input logic r, input logic f, input logic b, input logic [31:0] ba);
        rst = r;
        freeze = f;
        branch_taken = b;
        branch_address = ba;
        rnd_rdy = 1'($urandom_range(0, 1));
        #1;
        s_ready = mem_ready;
        if (model_on) model_check();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, 32'd0); advance();
        drive(1'b1, 1'b0, 1'b0, 32'd0); advance();
    endtask

    typedef struct {
        logic        r;
        logic        f;
        logic        v;
        logic [31:0] p;
        logic        q;
    } vec_t;

    vec_t tv[21];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;

        // Zero-wait start-up, reset mid-WAIT, then a 10-cycle freeze.
        tv[0]  = '{1'b1, 1'b0, 1'b0, 32'd0,  1'b0};
        tv[1]  = '{1'b0, 1'b0, 1'b0, 32'd0,  1'b1};
        tv[2]  = '{1'b0, 1'b0, 1'b1, 32'd4,  1'b1};
        tv[3]  = '{1'b0, 1'b0, 1'b1, 32'd8,  1'b1};
        tv[4]  = '{1'b0, 1'b0, 1'b1, 32'd12, 1'b1};
        tv[5]  = '{1'b1, 1'b0, 1'b1, 32'd16, 1'b0};
        tv[6]  = '{1'b1, 1'b0, 1'b0, 32'd0,  1'b0};
        tv[7]  = '{1'b0, 1'b0, 1'b0, 32'd0,  1'b1};
        tv[8]  = '{1'b0, 1'b1, 1'b1, 32'd4,  1'b1};
        tv[9]  = '{1'b0, 1'b1, 1'b1, 32'd4,  1'b1};
        tv[10] = '{1'b0, 1'b1, 1'b1, 32'd4,  1'b1};
        for (int i = 11; i <= 17; i++) tv[i] = '{1'b0, 1'b1, 1'b1, 32'd4, 1'b0};
        tv[18] = '{1'b0, 1'b0, 1'b1, 32'd4,  1'b0};
        tv[19] = '{1'b0, 1'b0, 1'b1, 32'd8,  1'b1};
        tv[20] = '{1'b0, 1'b0, 1'b1, 32'd12, 1'b1};

        ready_mode = 0;
        do_reset();
        for (int i = 0; i < 21; i++) begin
            drive(tv[i].r, tv[i].f, 1'b0, 32'd0);
            check($sformatf("vec%0d_valid", i), inst_valid, tv[i].v);
            check($sformatf("vec%0d_pc", i), pc, tv[i].p);
            check($sformatf("vec%0d_req", i), mem_req, tv[i].q);
            advance();
        end

        // 3-wait memory: redirect to 112 while the fetch of 8 is outstanding.
        ready_mode = 2;
        wait_n = 3;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, 1'b0, 1'b0, 32'd0); advance();
        end
        drive(1'b0, 1'b0, 1'b1, 32'd112);
        check("pre_branch_req", mem_req, 1'b1);
        check("pre_branch_addr", mem_addr, 32'd8);
        advance();
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        check("drop_req", mem_req, 1'b1);
        check("drop_addr", mem_addr, 32'd8);
        check("drop_valid", inst_valid, 1'b0);
        advance();
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            drive(1'b0, 1'b0, 1'b0, 32'd0);
            if (inst_valid) begin
                found = 1;
                check("redir_pc", pc, 32'd116);
                check("redir_inst", instruction, rom(32'd112));
            end
            advance();
        end
        check("redir_seen", 32'(found), 32'd1);

        // Redirect and freeze together: flush wins, target 184 (low bits ignored).
        ready_mode = 0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, 32'd0); advance();
        end
        drive(1'b0, 1'b1, 1'b1, 32'd187);
        check("bf_head_pc", pc, 32'd4);
        advance();
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        check("bf_flushed", inst_valid, 1'b0);
        check("bf_addr", mem_addr, 32'd184);
        advance();
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        check("bf_valid", inst_valid, 1'b1);
        check("bf_pc", pc, 32'd188);
        advance();

`ifdef IFU_STATS_EN
        // 20 fetches with one flush of 3 queued entries.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b0, 32'd0); advance();
        end
        drive(1'b0, 1'b0, 1'b0, 32'd0); advance();
        drive(1'b0, 1'b1, 1'b1, 32'd200); advance();
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b0, 1'b0, 32'd0); advance();
        end
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        check("stat_fetched", stat_fetched, 32'd20);
        check("stat_dropped", stat_dropped, 32'd3);
        advance();
`endif

        // Random handshake, freeze, redirect and occasional reset against the model.
        ready_mode = 1;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            drive(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 99) < 30),
                  1'($urandom_range(0, 99) < 6), $urandom);
            advance();
        end
        ready_mode = 2;
        wait_n = 2;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            drive(1'b0, 1'($urandom_range(0, 99) < 40), 1'($urandom_range(0, 99) < 4), $urandom);
            advance();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ifu_fetch_sequencer.md
# ifu_fetch_sequencer

Instruction-fetch sequencer for the ARM pipeline's IF stage. It owns the program counter, issues word-aligned read requests to the instruction memory over a request/ready handshake, buffers returned words with their PC+4 in a small prefetch queue, and presents them to the IF/ID register. It also honours the hazard unit's `freeze` and the EX stage's branch redirect, discarding in-flight and queued fetches on a redirect.

## Interface
- `RESET_PC`, 32'd0: PC loaded on reset.
- `QUEUE_DEPTH`, 4: prefetch queue entries (≥2, power of two).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `freeze` in 1: hazard stall; head entry held, no pop.
- `branch_taken` in 1: redirect request from EX.
- `branch_address` in 32: redirect target; bits [1:0] ignored.
- `mem_req` out 1: fetch request; held with `mem_addr` stable until `mem_ready`.
- `mem_addr` out 32: fetch address, bits [1:0] always 00.
- `mem_ready` in 1: read complete; `mem_rdata` valid this cycle; may assert in the same cycle as `mem_req`.
- `mem_rdata` in 32: fetched instruction word.
- `inst_valid` out 1: head entry valid.
- `instruction` out 32: head instruction, 32'd0 when not valid.
- `pc` out 32: head entry's PC+4, 32'd0 when not valid.

## Operation
- State machine: IDLE (no request), WAIT (request outstanding), DROP (outstanding request belongs to a flushed stream).
- IDLE→WAIT when `count + outstanding < QUEUE_DEPTH`; `mem_addr` = fetch PC. If `mem_ready` arrives in the same cycle, push and advance; remain in WAIT when room allows the next issue.
- WAIT: on `mem_ready`, push {fetch_pc+4, mem_rdata} and set fetch_pc += 4 (mod 2^32). Go to IDLE if queue now full, else issue next.
- Pop: when `inst_valid && !freeze`.
- Push and pop may occur in the same cycle; count unchanged.
- Redirect (`branch_taken`), priority over freeze, push and pop: queue cleared, fetch_pc ← {branch_address[31:2],2'b00}. If a request is outstanding and `mem_ready` is low, go to DROP; otherwise go to IDLE. A word returning in the redirect cycle is discarded.
- DROP: `mem_req` held on the old address until `mem_ready`; data discarded; then IDLE.
- Reset mid-request: all state cleared immediately. The memory must tolerate `mem_req` dropping without `mem_ready`.
- Reset values: `mem_req`=0, `mem_addr`=RESET_PC, `inst_valid`=0, `instruction`=0, `pc`=0, state IDLE, count 0.

## Timing
- Queue output is registered. A word accepted at edge t is visible at t+1.
- Zero-wait memory (`mem_ready` tied 1): first `inst_valid` one cycle after `rst` falls. Sustained throughput is 1 instruction/cycle.
- N-wait memory: throughput is 1/(N+1).
- Redirect at edge t: `inst_valid`=0 from t+1. The first target instruction appears at t+2 with zero-wait memory.
- `freeze` does not stop fetching until the queue fills.

## Configuration
- `IFU_STATS_EN` defined: adds 32-bit outputs `stat_fetched` (pushes) and `stat_dropped` (words discarded by a redirect, including queue entries flushed). Both are saturating and cleared by `rst`.
- Not defined: ports and counters are absent.

## Structure
- `ifu_pkg`: `ifu_state_t` enum (IDLE/WAIT/DROP), `fetch_entry_t` struct {pc_next[31:0], inst[31:0]}, `IFU_WORD_BYTES`=4.
- Sub-module `ifu_prefetch_queue`: synchronous FIFO of `fetch_entry_t` with push, pop, flush, count, and full/empty flags. Pointers wrap modulo `QUEUE_DEPTH`. Flush has priority.

## Test plan
- Reset, `mem_ready`=1, ROM words at 0/4/8 → `inst_valid` from cycle 1; `pc` = 4, 8, 12 on consecutive cycles.
- `freeze` high 10 cycles, DEPTH 4 → head held at `pc`=4; `mem_req` low after 4 entries; resumes one pop later.
- 3-wait memory, `branch_taken` with `branch_address`=112 while the fetch of 8 is outstanding → DROP; word for 8 discarded; next valid entry has `pc`=116.
- `branch_taken` and `freeze` in the same cycle, target 184 → queue flushed; first valid `pc`=188.
- `rst` asserted during WAIT → next cycle `mem_req`=0, `inst_valid`=0; refetch from `RESET_PC`.
- `IFU_STATS_EN`: 20 fetches with one flush of 3 queued entries → `stat_fetched`=20, `stat_dropped`=3.
